// File: rtl/cmp_stim_checker_if.sv
// Bus between the comparator self-test initiator and its environment.
// Carries the start pulse, the comparator result being checked, the
// operands fed to the comparator and the sweep status/result fields.
// "master" is the checker side; "slave" is the side that starts sweeps,
// owns the comparator and reads results.
interface cmp_stim_checker_if #(
  parameter int NBITS = 3,
  parameter int ERR_W = 8
);
  logic             start;
  logic             cmp_out;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [NBITS-1:0] fail_a;
  logic [NBITS-1:0] fail_b;

  modport master (
    input  start, cmp_out,
    output a, b, busy, done, pass, err_cnt, fail_a, fail_b
  );

  modport slave (
    output start, cmp_out,
    input  a, b, busy, done, pass, err_cnt, fail_a, fail_b
  );
endinterface

// File: rtl/cmp_stim_checker.sv
// Synthesizable self-test initiator for an equality comparator.
// Walks every (a, b) operand pair in ascending order, holds each pair for
// HOLD_CYCLES cycles, samples the comparator result on the last held cycle
// and checks it against a == b. Reports pass/fail, a saturating mismatch
// count and the first failing pair.
// Optional build macro CMP_STIM_STOP_ON_FAIL_EN: when defined, the first
// mismatch ends the sweep on its sampling edge with a/b left on the failing
// pair. When undefined the sweep always covers every pair.
// HOLD_CYCLES must be 2..255 and the comparator latency at most
// HOLD_CYCLES-1, so the sampled result belongs to the held pair.
module cmp_stim_checker #(
  parameter int NBITS       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  cmp_stim_checker_if.master  bus
);

  localparam int IDX_W = 2 * NBITS;
  localparam int HC_W  = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [HC_W-1:0]    r_hc;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               r_ff;
  logic [NBITS-1:0]   r_fail_a;
  logic [NBITS-1:0]   r_fail_b;

  logic               w_start_ok;
  logic               w_sample;
  logic               w_expect_eq;
  logic               w_mismatch;
  logic               w_last;
  logic               w_stop;
  logic               w_err_sat;

  // A start is only honoured outside a running sweep; IDLE and DONE both
  // restart immediately.
  assign w_start_ok  = (r_state != S_RUN) && bus.start;
  assign w_sample    = (r_state == S_RUN) && (r_hc == HC_LAST);
  assign w_expect_eq = (r_idx[IDX_W-1:NBITS] == r_idx[NBITS-1:0]);
  assign w_mismatch  = w_sample && (bus.cmp_out != w_expect_eq);
  assign w_last      = &r_idx;
  assign w_err_sat   = &r_err_cnt;

`ifdef CMP_STIM_STOP_ON_FAIL_EN
  assign w_stop = w_sample && (w_last || w_mismatch);
`else
  assign w_stop = w_sample && w_last;
`endif

  // State register; reset aborts any sweep straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision: start leaves IDLE/DONE, the final (or stopping)
  // sample leaves RUN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_stop)    w_state_nxt = S_DONE;
      S_DONE:  if (bus.start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sweep datapath: operand index, hold counter, error count and the
  // first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_hc      <= '0;
      r_err_cnt <= '0;
      r_ff      <= 1'b0;
      r_fail_a  <= '0;
      r_fail_b  <= '0;
    end else if (w_start_ok) begin
      r_idx     <= '0;
      r_hc      <= '0;
      r_err_cnt <= '0;
      r_ff      <= 1'b0;
      r_fail_a  <= '0;
      r_fail_b  <= '0;
    end else if (r_state == S_RUN) begin
      if (!w_sample) begin
        r_hc <= r_hc + HC_W'(1);
      end else begin
        if (w_mismatch) begin
          if (!w_err_sat) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
          end
          if (!r_ff) begin
            r_fail_a <= r_idx[IDX_W-1:NBITS];
            r_fail_b <= r_idx[NBITS-1:0];
            r_ff     <= 1'b1;
          end
        end
        if (!w_stop) begin
          r_idx <= r_idx + IDX_W'(1);
          r_hc  <= '0;
        end
      end
    end
  end

  // Outputs decoded from registered state only, so they are glitch-free.
  always_comb begin
    bus.a       = r_idx[IDX_W-1:NBITS];
    bus.b       = r_idx[NBITS-1:0];
    bus.busy    = (r_state == S_RUN);
    bus.done    = (r_state == S_DONE);
    bus.pass    = (r_state == S_DONE) && (r_err_cnt == '0);
    bus.err_cnt = r_err_cnt;
    bus.fail_a  = r_fail_a;
    bus.fail_b  = r_fail_b;
  end

endmodule

// File: tb/tb_cmp_stim_checker.sv
// Testbench for cmp_stim_checker. Two instances run in lockstep (8-bit and
// 4-bit error counters), each beside a registered comparator model whose
// answer can be corrupted per operand pair via faultMask. Expected results
// come from a pair-list model of the sweep.
module tb_cmp_stim_checker;

  localparam int NBITS  = 3;
  localparam int HOLD   = 4;
  localparam int NPAIRS = 1 << (2 * NBITS);
  localparam int FULL   = NPAIRS * HOLD;

  bit clk = 1'b0;
  logic rst_n;
  logic start;
  bit cmp8;
  bit cmp4;
  bit faultMask [NPAIRS];

  int checks = 0;
  int failures = 0;

  int obsBusyCycles;
  int obsSeqErr;
  bit obsTimeout;
  logic obsFirstBusy;
  logic obsFirstDone;
  logic [NBITS-1:0] obsFirstA;
  logic [NBITS-1:0] obsFirstB;
  logic [7:0] obsFirstErr;

  cmp_stim_checker_if #(.NBITS(NBITS), .ERR_W(8)) if8 ();
  cmp_stim_checker_if #(.NBITS(NBITS), .ERR_W(4)) if4 ();

  cmp_stim_checker #(.NBITS(NBITS), .HOLD_CYCLES(HOLD), .ERR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8)
  );
  cmp_stim_checker #(.NBITS(NBITS), .HOLD_CYCLES(HOLD), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
  );

  assign if8.start   = start;
  assign if4.start   = start;
  assign if8.cmp_out = cmp8;
  assign if4.cmp_out = cmp4;

  always #5 clk = ~clk;

  // Registered equality comparators with optional per-pair corruption.
  always @(posedge clk) begin
    cmp8 <= (if8.a == if8.b) ^ faultMask[{if8.a, if8.b}];
    cmp4 <= (if4.a == if4.b) ^ faultMask[{if4.a, if4.b}];
  end

  task automatic setMaskClean();
    for (int i = 0; i < NPAIRS; i++) faultMask[i] = 1'b0;
  endtask

  // Count corrupted pairs and locate the first one in sweep order.
  task automatic modelSweep(output int cnt, output int firstIdx);
    cnt = 0;
    firstIdx = -1;
    for (int i = 0; i < NPAIRS; i++) begin
      if (faultMask[i]) begin
        cnt++;
        if (firstIdx < 0) firstIdx = i;
      end
    end
  endtask

  // Pulse start, follow the sweep to done and record what was observed.
  task automatic runSweep(input bit pulseMid);
    int cycle;
    obsSeqErr = 0;
    obsBusyCycles = 0;
    obsTimeout = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    obsFirstBusy = if8.busy;
    obsFirstDone = if8.done;
    obsFirstA    = if8.a;
    obsFirstB    = if8.b;
    obsFirstErr  = if8.err_cnt;
    cycle = 0;
    while (!if8.done && cycle < 2000) begin
      if (if8.busy) begin
        obsBusyCycles++;
        if ({if8.a, if8.b} !== 6'(cycle / HOLD)) obsSeqErr++;
        if ({if4.a, if4.b} !== {if8.a, if8.b}) obsSeqErr++;
      end else begin
        obsSeqErr++;
      end
      start = pulseMid && (cycle == 50);
      @(negedge clk);
      cycle++;
    end
    start = 1'b0;
    if (!if8.done) obsTimeout = 1'b1;
  endtask

  // Run one sweep with the current faultMask and compare every result.
  task automatic test_mask_sweep(input string label, input bit pulseMid);
    int cnt, first, expBusy, expErr8, expErr4, endIdx, failIdx;
    bit expPass;
    modelSweep(cnt, first);
`ifdef CMP_STIM_STOP_ON_FAIL_EN
    if (first >= 0) begin
      expBusy = (first + 1) * HOLD;
      expErr8 = 1;
      expErr4 = 1;
      endIdx  = first;
    end else begin
      expBusy = FULL;
      expErr8 = 0;
      expErr4 = 0;
      endIdx  = NPAIRS - 1;
    end
`else
    expBusy = FULL;
    expErr8 = (cnt > 255) ? 255 : cnt;
    expErr4 = (cnt > 15) ? 15 : cnt;
    endIdx  = NPAIRS - 1;
`endif
    expPass = (cnt == 0);
    failIdx = (first >= 0) ? first : 0;
    runSweep(pulseMid);

    checks++;
    if (obsTimeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s timeout got done=%0b exp=1", label, if8.done);
    end
    checks++;
    if (obsBusyCycles !== expBusy) begin
      failures++;
      $display("[TB] FAIL %s busy_cycles got=%0d exp=%0d", label, obsBusyCycles, expBusy);
    end
    checks++;
    if (obsSeqErr !== 0) begin
      failures++;
      $display("[TB] FAIL %s operand_order got=%0d bad_cycles exp=0", label, obsSeqErr);
    end
    checks++;
    if ({if8.busy, if8.done, if4.done} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL %s end_flags got busy=%0b done=%0b done4=%0b exp 0,1,1", label, if8.busy, if8.done, if4.done);
    end
    checks++;
    if (if8.pass !== expPass) begin
      failures++;
      $display("[TB] FAIL %s pass got=%0b exp=%0b", label, if8.pass, expPass);
    end
    checks++;
    if (if8.err_cnt !== 8'(expErr8)) begin
      failures++;
      $display("[TB] FAIL %s err_cnt8 got=%0d exp=%0d", label, if8.err_cnt, expErr8);
    end
    checks++;
    if (if4.err_cnt !== 4'(expErr4)) begin
      failures++;
      $display("[TB] FAIL %s err_cnt4 got=%0d exp=%0d", label, if4.err_cnt, expErr4);
    end
    checks++;
    if ({if8.fail_a, if8.fail_b} !== 6'(failIdx)) begin
      failures++;
      $display("[TB] FAIL %s fail_pair got=%0d,%0d exp=%0d,%0d", label, if8.fail_a, if8.fail_b, failIdx / 8, failIdx % 8);
    end
    checks++;
    if ({if8.a, if8.b} !== 6'(endIdx)) begin
      failures++;
      $display("[TB] FAIL %s final_ab got=%0d,%0d exp=%0d,%0d", label, if8.a, if8.b, endIdx / 8, endIdx % 8);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({if8.busy, if8.done, if8.pass, if8.a, if8.b} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_flags got busy=%0b done=%0b pass=%0b a=%0d b=%0d exp all 0", if8.busy, if8.done, if8.pass, if8.a, if8.b);
    end
    checks++;
    if ({if8.err_cnt, if8.fail_a, if8.fail_b} !== 14'd0) begin
      failures++;
      $display("[TB] FAIL reset_results got err=%0d fail=%0d,%0d exp 0", if8.err_cnt, if8.fail_a, if8.fail_b);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({if8.busy, if8.done, if8.a, if8.b} !== 8'd0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got busy=%0b done=%0b a=%0d b=%0d exp 0", if8.busy, if8.done, if8.a, if8.b);
    end
  endtask

  task automatic test_clean_sweep();
    setMaskClean();
    test_mask_sweep("clean", 1'b0);
  endtask

  task automatic test_stuck_zero();
    for (int i = 0; i < NPAIRS; i++) faultMask[i] = ((i / 8) == (i % 8));
    test_mask_sweep("stuck0", 1'b0);
  endtask

  task automatic test_stuck_one();
    for (int i = 0; i < NPAIRS; i++) faultMask[i] = ((i / 8) != (i % 8));
    test_mask_sweep("stuck1", 1'b0);
  endtask

  task automatic test_single_fault();
    setMaskClean();
    faultMask[18] = 1'b1;
    test_mask_sweep("pair_2_2", 1'b0);
  endtask

  task automatic test_random_faults();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NPAIRS; i++) begin
        if (k == 3) faultMask[i] = ($urandom_range(0, 1) == 0);
        else        faultMask[i] = ($urandom_range(0, 15) == 0);
      end
      test_mask_sweep($sformatf("random%0d", k), 1'b0);
    end
  endtask

  task automatic test_start_while_busy();
    setMaskClean();
    test_mask_sweep("start_mid", 1'b1);
  endtask

  task automatic test_restart_from_done();
    for (int i = 0; i < NPAIRS; i++) faultMask[i] = ((i / 8) != (i % 8));
    runSweep(1'b0);
    setMaskClean();
    test_mask_sweep("restart", 1'b0);
    checks++;
    if ({obsFirstBusy, obsFirstDone, obsFirstA, obsFirstB} !== 8'b1000_0000) begin
      failures++;
      $display("[TB] FAIL restart_first_cycle got busy=%0b done=%0b a=%0d b=%0d exp 1,0,0,0", obsFirstBusy, obsFirstDone, obsFirstA, obsFirstB);
    end
    checks++;
    if (obsFirstErr !== 8'd0) begin
      failures++;
      $display("[TB] FAIL restart_err_clear got=%0d exp=0", obsFirstErr);
    end
  endtask

  task automatic test_reset_mid_sweep();
    setMaskClean();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.busy, if8.done, if8.pass, if8.a, if8.b, if8.err_cnt} !== 17'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid got busy=%0b done=%0b a=%0d b=%0d err=%0d exp 0", if8.busy, if8.done, if8.a, if8.b, if8.err_cnt);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({if8.busy, if8.done, if8.a, if8.b} !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_idle got busy=%0b done=%0b a=%0d b=%0d exp 0", if8.busy, if8.done, if8.a, if8.b);
    end
    test_mask_sweep("after_reset", 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    setMaskClean();
    repeat (2) @(negedge clk);
    test_reset();
    test_clean_sweep();
    test_stuck_zero();
    test_stuck_one();
    test_single_fault();
    test_random_faults();
    test_start_while_busy();
    test_restart_from_done();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
